// File: rtl/sum_of_squares.sv
// Sequential x^2 + y^2 front-end for the vector-magnitude path.
// One shift-add multiplier squares |x| then |y| into a shared accumulator.
module sum_of_squares #(
  parameter int IN_WIDTH = 16,
  parameter int WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_WIDTH-1:0] x,
  input  logic signed [IN_WIDTH-1:0] y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           sum_out
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);
  localparam logic [IN_WIDTH-1:0] ONE = IN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    SQ_X,
    SQ_Y,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [IN_WIDTH-1:0] mplier_q, mplier_d;
  logic [IN_WIDTH-1:0] absy_q, absy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                ov_q, ov_d;

  logic [IN_WIDTH-1:0] abs_x;
  logic [IN_WIDTH-1:0] abs_y;
  logic [WIDTH-1:0]    acc_step;

  // Two's-complement magnitude; -2^(N-1) maps to 2^(N-1) unsigned.
  assign abs_x = x[IN_WIDTH-1] ? (~x + ONE) : x;
  assign abs_y = y[IN_WIDTH-1] ? (~y + ONE) : y;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign sum_out   = sum_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    absy_d   = absy_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    ov_d     = ov_q;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    if (stall) begin
      state_d  = IDLE;
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      absy_d   = '0;
      cnt_d    = '0;
      sum_d    = '0;
      ov_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d  = SQ_X;
            acc_d    = '0;
            mcand_d  = {{(WIDTH-IN_WIDTH){1'b0}}, abs_x};
            mplier_d = abs_x;
            absy_d   = abs_y;
            cnt_d    = '0;
          end
        end
        SQ_X, SQ_Y: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (state_q == SQ_X) begin
              state_d  = SQ_Y;
              mcand_d  = {{(WIDTH-IN_WIDTH){1'b0}}, absy_q};
              mplier_d = absy_q;
            end else begin
              state_d = DONE;
              sum_d   = acc_step;
              ov_d    = 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            ov_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      absy_q   <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      absy_q   <= absy_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      ov_q     <= ov_d;
    end
  end

endmodule
